demux_32x8: RTL and testbench

//  Word-to-byte serializer; the transmit-side counterpart of the 8x32 byte-packing mux.

---
 rtl/demux_32x8_if.sv | 28 ++
 rtl/demux_32x8.sv | 118 +++++++++++
 tb/tb_demux_32x8.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/demux_32x8_if.sv
// Word-in / byte-out bus of the 32-to-8 serializer.
// The master drives words in; the slave (the serializer) drives bytes out.
interface demux_32x8_if;
  logic [31:0] data_in_32x8;
  logic        valid_in_32x8;
  logic        ready_in_32x8;
  logic [7:0]  data_out_32x8;
  logic        valid_out_32x8;
  logic        overflow;

  modport master (
    output data_in_32x8,
    output valid_in_32x8,
    input  ready_in_32x8,
    input  data_out_32x8,
    input  valid_out_32x8,
    input  overflow
  );

  modport slave (
    input  data_in_32x8,
    input  valid_in_32x8,
    output ready_in_32x8,
    output data_out_32x8,
    output valid_out_32x8,
    output overflow
  );
endinterface

// File: rtl/demux_32x8.sv
// Word-to-byte serializer: 32-bit words enter a small FIFO through valid/ready
// and leave as 4 back-to-back registered bytes on the clk_4f domain.
module demux_32x8 #(
  parameter int MSB_FIRST = 1,
  parameter int DEPTH     = 2
) (
  input  logic         clk_4f,
  input  logic         reset,
  demux_32x8_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  state_t        r_state;
  logic [1:0]    r_cnt;
  logic [31:0]   r_word;
  logic [7:0]    r_data_out;
  logic          r_valid_out;

  logic          w_empty;
  logic          w_full;
  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_head;

  // Byte k of a word in transmit order.
  function automatic logic [7:0] sel_byte(input logic [31:0] word, input logic [1:0] k);
    logic [1:0] idx;
    idx = (MSB_FIRST != 0) ? ~k : k;
    return word[{idx, 3'b000} +: 8];
  endfunction

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_COUNT);
  assign w_ready = !reset && !w_full;
  assign w_push  = bus.valid_in_32x8 && w_ready;
  // Refill while the last byte of the current word is on the wire, so words chain with no bubble.
  assign w_pop   = !w_empty && ((r_state == IDLE) || (r_state == SEND && r_cnt == 2'd3));
  assign w_head  = r_mem[r_rd_ptr];

  // NOTE: the word storage has no reset; pointers and count alone decide which entries are live.
  always_ff @(posedge clk_4f) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.data_in_32x8;
  end

  // NOTE: sequential state uses <= so every register here sees the pre-edge values of the others.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (bus.valid_in_32x8 && !w_ready) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_word      <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_word      <= w_head;
            r_data_out  <= sel_byte(w_head, 2'd0);
            r_valid_out <= 1'b1;
            r_cnt       <= 2'd1;
            r_state     <= SEND;
          end else begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_cnt       <= '0;
          end
        end
        SEND: begin
          r_data_out  <= sel_byte(r_word, r_cnt);
          r_valid_out <= 1'b1;
          r_cnt       <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            if (w_pop) r_word  <= w_head;
            else       r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ready_in_32x8  = w_ready;
  assign bus.data_out_32x8  = r_data_out;
  assign bus.valid_out_32x8 = r_valid_out;
  assign bus.overflow       = r_overflow;
endmodule

// File: tb/tb_demux_32x8.sv
// Bench for demux_32x8: both byte orders side by side, a queue of expected bytes
// per order, and a cycle model of FIFO occupancy for valid/ready/overflow timing.
module tb_demux_32x8;
  localparam int DEPTH = 2;

  logic clk_4f = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_4f = ~clk_4f;

  logic        drv_valid;
  logic [31:0] drv_data;

  demux_32x8_if if_a ();
  demux_32x8_if if_b ();

  assign if_a.valid_in_32x8 = drv_valid;
  assign if_a.data_in_32x8  = drv_data;
  assign if_b.valid_in_32x8 = drv_valid;
  assign if_b.data_in_32x8  = drv_data;

  demux_32x8 #(.MSB_FIRST(1), .DEPTH(DEPTH)) u_msb (.clk_4f(clk_4f), .reset(reset), .bus(if_a));
  demux_32x8 #(.MSB_FIRST(0), .DEPTH(DEPTH)) u_lsb (.clk_4f(clk_4f), .reset(reset), .bus(if_b));

  // Reference: words waiting in the FIFO, bytes still owed by the serializer,
  // and the expected byte streams in each order.
  int         m_fifo_n;
  int         m_pend;
  bit         m_valid;
  bit         m_ovf;
  logic [7:0] exp_msb[$];
  logic [7:0] exp_lsb[$];

  int n_cmp;
  int n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_flush();
    m_fifo_n = 0;
    m_pend   = 0;
    m_valid  = 1'b0;
    m_ovf    = 1'b0;
    exp_msb.delete();
    exp_lsb.delete();
  endtask

  // One clock edge of the reference: decisions use the pre-edge occupancy.
  task automatic model_edge();
    bit ready_pre;
    if (reset) begin
      model_flush();
      return;
    end
    ready_pre = (m_fifo_n < DEPTH);
    if (m_pend <= 1 && m_fifo_n > 0) begin
      m_fifo_n--;
      m_pend += 4;
    end
    if (m_pend > 0) begin
      m_valid = 1'b1;
      m_pend--;
    end else begin
      m_valid = 1'b0;
    end
    if (drv_valid) begin
      if (ready_pre) begin
        m_fifo_n++;
        for (int k = 0; k < 4; k++) begin
          exp_msb.push_back(8'(drv_data >> (8 * (3 - k))));
          exp_lsb.push_back(8'(drv_data >> (8 * k)));
        end
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic step(input bit v, input logic [31:0] d);
    drv_valid = v;
    drv_data  = d;
    @(posedge clk_4f);
    model_edge();
    #1;
  endtask

  // Called at posedge+1: asserts reset mid-cycle, checks outputs clear at once,
  // holds it across one edge and releases it at the following posedge+1.
  task automatic async_reset_check();
    drv_valid = 1'b0;
    #2;
    reset = 1'b1;
    model_flush();
    #1;
    check("rst_valid_msb", 32'(if_a.valid_out_32x8), 32'd0);
    check("rst_valid_lsb", 32'(if_b.valid_out_32x8), 32'd0);
    check("rst_data_msb",  32'(if_a.data_out_32x8),  32'd0);
    check("rst_ready",     32'(if_a.ready_in_32x8),  32'd0);
    check("rst_overflow",  32'(if_a.overflow),       32'd0);
    @(posedge clk_4f);
    model_edge();
    #1;
    reset = 1'b0;
  endtask

  always @(negedge clk_4f) begin : p_monitor
    logic [7:0] e;
    check("valid_msb", 32'(if_a.valid_out_32x8), 32'(m_valid));
    check("valid_lsb", 32'(if_b.valid_out_32x8), 32'(m_valid));
    check("ready",     32'(if_a.ready_in_32x8),  32'(!reset && (m_fifo_n < DEPTH)));
    check("overflow",  32'(if_a.overflow),       32'(m_ovf));
    check("overflow_lsb", 32'(if_b.overflow),    32'(m_ovf));
    if (if_a.valid_out_32x8) begin
      if (exp_msb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL byte_msb: got %0h expected no byte at %0t", if_a.data_out_32x8, $time);
      end else begin
        e = exp_msb.pop_front();
        check("byte_msb", 32'(if_a.data_out_32x8), 32'(e));
      end
    end else begin
      check("idle_data_msb", 32'(if_a.data_out_32x8), 32'd0);
    end
    if (if_b.valid_out_32x8) begin
      if (exp_lsb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL byte_lsb: got %0h expected no byte at %0t", if_b.data_out_32x8, $time);
      end else begin
        e = exp_lsb.pop_front();
        check("byte_lsb", 32'(if_b.data_out_32x8), 32'(e));
      end
    end else begin
      check("idle_data_lsb", 32'(if_b.data_out_32x8), 32'd0);
    end
  end

  initial begin
    int guard;
    n_cmp = 0;
    n_bad = 0;
    drv_valid = 1'b0;
    drv_data  = '0;
    model_flush();

    repeat (3) step(1'b0, '0);
    reset = 1'b0;
    step(1'b0, '0);

    // Single word, then idle until it drains.
    step(1'b1, 32'hA1B2C3D4);
    repeat (6) step(1'b0, '0);

    // Two words on consecutive edges: eight contiguous bytes.
    step(1'b1, 32'h01020304);
    step(1'b1, 32'h05060708);
    repeat (10) step(1'b0, '0);

    step(1'b1, 32'h11223344);
    repeat (6) step(1'b0, '0);

    // First word starts serializing while three more are offered; the last is dropped.
    step(1'b1, 32'hCAFE0001);
    step(1'b1, 32'hCAFE0002);
    step(1'b1, 32'hCAFE0003);
    step(1'b1, 32'hCAFE0004);
    repeat (14) step(1'b0, '0);

    // Reset after byte 2 of a word with one more word queued.
    step(1'b1, 32'hDEADBEEF);
    step(1'b1, 32'h12345678);
    step(1'b0, '0);
    step(1'b0, '0);
    async_reset_check();
    repeat (8) step(1'b0, '0);

    // Ten words paced by the reference's own ready, wrapping the pointers.
    for (int i = 0; i < 10; i++) begin
      guard = 0;
      while (m_fifo_n >= DEPTH && guard < 20) begin
        step(1'b0, '0);
        guard++;
      end
      step(1'b1, $urandom);
    end
    repeat (8) step(1'b0, '0);

    // Random offers, including ones refused while full, and a reset mid-stream.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) async_reset_check();
      step($urandom_range(0, 99) < 55, $urandom);
    end
    repeat (12) step(1'b0, '0);

    check("drained_msb", 32'(exp_msb.size()), 32'd0);
    check("drained_lsb", 32'(exp_lsb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
